led_pattern_gen: RTL and testbench

Multi-channel LED pattern generator: the parametrised successor to the single fixed-rate heartbeat blinker. It drives `NUM_CH` LED outputs, each independently configurable as off, on, blink with programmable period and duty, or a counted flash burst. Timing derives from one shared millisecond-style tick prescaler. It sits between board-level LED pins and any control logic (CPU register file, test sequencer) through a single-cycle configuration write port.

---
 rtl/led_pattern_gen.sv | 142 ++++++++++++++
 tb/tb_led_pattern_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: NUM_CH independent LED channels (off / on / blink / counted
// pulse burst). All channels share one tick prescaler and are configured
// through a single-cycle write port.
//
// Per-channel mode register:
//   state      | meaning
//   MODE_OFF   | LED never lit, phase held at 0
//   MODE_ON    | LED always lit, phase held at 0
//   MODE_BLINK | LED lit while ph < duty, ph wraps every period ticks
//   MODE_PULSE | as BLINK, but each period end consumes one flash; drops to OFF at zero
module led_pattern_gen #(
  parameter int         NUM_CH      = 4,
  parameter int         TICK_DIV    = 50000,
  parameter int         CNT_W       = 16,
  parameter int         ACTIVE_HIGH = 1,
  parameter logic [1:0] RST_MODE    = 2'd2,
  parameter int         RST_PERIOD  = 1000,
  parameter int         RST_DUTY    = 500,
  localparam int        CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_duty,
  input  logic [7:0]        cfg_count,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done
);

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_PULSE = 2'd3;

  localparam int            TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  // XOR mask applied to the lit condition; also the inactive (reset) LED level
  localparam logic          LED_INV   = (ACTIVE_HIGH == 0);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

  // Free-running tick prescaler; config writes never disturb it
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) tick_cnt_q <= '0;
    else            tick_cnt_q <= tick_cnt_d;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] ph_q, ph_d;
    logic [7:0]       rem_q, rem_d;
    logic             led_q, led_d;
    logic             done_q, done_d;
    logic             sel, running, lit;

    // Out-of-range channel numbers match no channel, so such writes vanish
    assign sel     = cfg_we && (cfg_ch == CH_W'(i));
    assign running = (mode_q == MODE_BLINK) || (mode_q == MODE_PULSE);

    // Lit condition from the current registered state; a PULSE with no
    // flashes left never lights even for the cycle before it turns OFF
    always_comb begin
      lit = 1'b0;
      case (mode_q)
        MODE_ON:    lit = 1'b1;
        MODE_BLINK: lit = (period_q != '0) && (ph_q < duty_q);
        MODE_PULSE: lit = (period_q != '0) && (ph_q < duty_q) && (rem_q != 8'd0);
        default:    lit = 1'b0;
      endcase
    end

    // Next-state: a write beats a same-cycle tick; an empty PULSE retires at once
    always_comb begin
      mode_d   = mode_q;
      period_d = period_q;
      duty_d   = duty_q;
      ph_d     = ph_q;
      rem_d    = rem_q;
      done_d   = 1'b0;
      led_d    = lit ^ LED_INV;
      if (sel) begin
        mode_d   = cfg_mode;
        period_d = cfg_period;
        duty_d   = cfg_duty;
        rem_d    = cfg_count;
        ph_d     = '0;
      end else if ((mode_q == MODE_PULSE) && (rem_q == 8'd0)) begin
        mode_d = MODE_OFF;
        done_d = 1'b1;
      end else if (tick && running && (period_q != '0)) begin
        if (ph_q == period_q - CNT_W'(1)) begin
          ph_d = '0;
          if (mode_q == MODE_PULSE) begin
            rem_d = rem_q - 8'd1;
            if (rem_q == 8'd1) begin
              mode_d = MODE_OFF;
              done_d = 1'b1;
            end
          end
        end else begin
          ph_d = ph_q + CNT_W'(1);
        end
      end
    end

    // Channel state and registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        mode_q   <= RST_MODE;
        period_q <= CNT_W'(RST_PERIOD);
        duty_q   <= CNT_W'(RST_DUTY);
        ph_q     <= '0;
        rem_q    <= 8'd0;
        led_q    <= LED_INV;
        done_q   <= 1'b0;
      end else begin
        mode_q   <= mode_d;
        period_q <= period_d;
        duty_q   <= duty_d;
        ph_q     <= ph_d;
        rem_q    <= rem_d;
        led_q    <= led_d;
        done_q   <= done_d;
      end
    end

    assign led[i]  = led_q;
    assign done[i] = done_q;
    assign busy[i] = (mode_q == MODE_PULSE) && (rem_q != 8'd0);
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: default blink, polarity, duty corners,
// write/tick collision, pulse bursts, bad channel address, reset mid-burst.
module tb_led_pattern_gen;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b1;
  logic       cfg_we     = 1'b0;
  logic [1:0] cfg_ch     = 2'd0;
  logic [1:0] cfg_mode   = 2'd0;
  logic [7:0] cfg_period = 8'd0;
  logic [7:0] cfg_duty   = 8'd0;
  logic [7:0] cfg_count  = 8'd0;
  logic [3:0] led, busy, done;
  logic [2:0] led_n, busy_n, done_n;

  int vec = 0;
  int err = 0;
  int ec  = 0;

  logic [3:0] exp4;
  logic [2:0] exp3;

  logic [7:0] dc_per [4] = '{8'd8, 8'd8, 8'd8,  8'd0};
  logic [7:0] dc_duty[4] = '{8'd0, 8'd8, 8'd12, 8'd12};
  logic       dc_exp [4] = '{1'b0, 1'b1, 1'b1,  1'b0};

  led_pattern_gen #(
    .NUM_CH(4), .TICK_DIV(4), .CNT_W(8), .ACTIVE_HIGH(1),
    .RST_MODE(2'd2), .RST_PERIOD(10), .RST_DUTY(5)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .cfg_count(cfg_count), .led(led), .busy(busy), .done(done)
  );

  // Three-channel, active-low instance: checks polarity and that channel 3 is rejected
  led_pattern_gen #(
    .NUM_CH(3), .TICK_DIV(4), .CNT_W(8), .ACTIVE_HIGH(0),
    .RST_MODE(2'd2), .RST_PERIOD(10), .RST_DUTY(5)
  ) dut_n (
    .sys_clk(clk), .sys_rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .cfg_count(cfg_count), .led(led_n), .busy(busy_n), .done(done_n)
  );

  always #5 clk = ~clk;

  // Edges since reset release; ticks land on edges where ec becomes a multiple of 4
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ec <= 0;
    else        ec <= ec + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] m,
                    input logic [7:0] p, input logic [7:0] d, input logic [7:0] c);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = m;
    cfg_period = p; cfg_duty = d; cfg_count = c;
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Wait at negedges until the next posedge consumes a tick
  task automatic align_tick();
    for (int i = 0; i < 4 && ((ec + 1) % 4) != 0; i++) @(negedge clk);
  endtask

  // Default blink (period 10, duty 5, 4 clocks/tick): high 20, low 20, from edge 1
  function automatic logic pat(input int n);
    return ((n - 1) % 40) < 20;
  endfunction

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_led",    led,    32'h0);
    chk("rst_busy",   busy,   32'h0);
    chk("rst_done",   done,   32'h0);
    chk("rst_led_n",  led_n,  32'h7);
    chk("rst_busy_n", busy_n, 32'h0);
    chk("rst_done_n", done_n, 32'h0);

    // Default blink; a write to ch3 at edge 31 turns main ch3 OFF and is ignored by dut_n
    rst_n = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      exp4 = {(n >= 32) ? 1'b0 : pat(n), {3{pat(n)}}};
      exp3 = ~{3{pat(n)}};
      chk("blink_led", led, exp4);
      chk("blink_led_inv", led_n, exp3);
      if (n % 10 == 0) begin
        chk("blink_busy", busy, 32'h0);
        chk("blink_done", done, 32'h0);
      end
      if (n == 30) begin
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_mode = 2'd0;
        cfg_period = 8'd0; cfg_duty = 8'd0; cfg_count = 8'd0;
      end
      if (n == 31) cfg_we = 1'b0;
    end

    // Duty corners on ch1
    for (int j = 0; j < 4; j++) begin
      wr(2'd1, 2'd2, dc_per[j], dc_duty[j], 8'd0);
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        chk("duty_corner", led[1], dc_exp[j]);
      end
    end

    // Write on a tick edge: the tick is dropped, ph restarts at 0
    align_tick();
    wr(2'd0, 2'd2, 8'd2, 8'd1, 8'd0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("collision_led0", led[0], ((k - 1) % 8) < 4);
    end

    // PULSE burst of 3 on ch2, written on a tick edge
    align_tick();
    wr(2'd2, 2'd3, 8'd4, 8'd2, 8'd3);
    chk("pulse_busy0", busy[2], 32'h1);
    chk("pulse_done0", done[2], 32'h0);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      chk("pulse_led",  led[2],  (k <= 40) && (((k - 1) % 16) < 8));
      chk("pulse_busy", busy[2], k <= 47);
      chk("pulse_done", done[2], k == 48);
    end

    // PULSE with count 0 retires on the next cycle and never lights
    wr(2'd2, 2'd3, 8'd4, 8'd2, 8'd0);
    chk("cnt0_busy0", busy[2], 32'h0);
    chk("cnt0_done0", done[2], 32'h0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("cnt0_done", done[2], k == 1);
      chk("cnt0_led",  led[2],  32'h0);
      chk("cnt0_busy", busy[2], 32'h0);
    end

    // Reset in the middle of a ch3 burst with two flashes remaining
    align_tick();
    wr(2'd3, 2'd3, 8'd2, 8'd2, 8'd3);
    repeat (10) @(negedge clk);
    chk("mid_led3",  led[3],  32'h1);
    chk("mid_busy3", busy[3], 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_led",   led,   32'h0);
    chk("async_busy",  busy,  32'h0);
    chk("async_done",  done,  32'h0);
    chk("async_led_n", led_n, 32'h7);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      exp4 = {4{pat(n)}};
      chk("post_rst_led",  led,  exp4);
      chk("post_rst_done", done, 32'h0);
      chk("post_rst_busy", busy, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
